// File: rtl/i2c_reg_pkg.sv
// Shared types and widths for the I2C/host register arbiter.
// Holds the host FSM state encoding and the address range check.
package i2c_reg_pkg;

    localparam int REG_W  = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } host_state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
        return (int'(addr) < depth);
    endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// DEPTH x 8 register storage: one write port muxed with I2C priority over host,
// two combinational read ports and a flattened view of every register.
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int               DEPTH     = 32,
    parameter logic [REG_W-1:0] RESET_VAL = 8'h00
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    i_i2c_wr_en,
    input  logic [ADDR_W-1:0]       i_i2c_addr,
    input  logic [REG_W-1:0]        i_i2c_wdata,
    input  logic                    i_host_wr_en,
    input  logic [ADDR_W-1:0]       i_host_addr,
    input  logic [REG_W-1:0]        i_host_wdata,
    input  logic [ADDR_W-1:0]       i_rd0_addr,
    output logic [REG_W-1:0]        o_rd0_data,
    input  logic [ADDR_W-1:0]       i_rd1_addr,
    output logic [REG_W-1:0]        o_rd1_data,
    output logic [DEPTH*REG_W-1:0]  o_regs_flat
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [REG_W-1:0] r_bank [DEPTH];
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [REG_W-1:0] w_wr_data;

    // Out-of-range writes are dropped here, so the FSM never has to care.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        if (i_i2c_wr_en && addr_in_range(i_i2c_addr, DEPTH)) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = i_i2c_addr[IDX_W-1:0];
            w_wr_data = i_i2c_wdata;
        end else if (i_host_wr_en && addr_in_range(i_host_addr, DEPTH)) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = i_host_addr[IDX_W-1:0];
            w_wr_data = i_host_wdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            r_bank[w_wr_idx] <= w_wr_data;
        end
    end

    assign o_rd0_data = addr_in_range(i_rd0_addr, DEPTH) ? r_bank[i_rd0_addr[IDX_W-1:0]] : '0;
    assign o_rd1_data = addr_in_range(i_rd1_addr, DEPTH) ? r_bank[i_rd1_addr[IDX_W-1:0]] : '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_regs_flat[g*REG_W +: REG_W] = r_bank[g];
    end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Arbitrates a shared register bank between the I2C slave (absolute priority) and a host req/ack port.
// Define I2C_REG_IRQ_EN to build per-register change flags and the irq output.
module i2c_reg_arbiter
    import i2c_reg_pkg::*;
#(
    parameter int               DEPTH     = 32,
    parameter logic [REG_W-1:0] RESET_VAL = 8'h00
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    i2c_wr_en,
    input  logic [ADDR_W-1:0]       i2c_addr,
    input  logic [REG_W-1:0]        i2c_wr_data,
    output logic [REG_W-1:0]        i2c_rd_data,
    input  logic                    host_req,
    input  logic                    host_we,
    input  logic [ADDR_W-1:0]       host_addr,
    input  logic [REG_W-1:0]        host_wdata,
    output logic                    host_ack,
    output logic [REG_W-1:0]        host_rdata,
    output logic [DEPTH*REG_W-1:0]  regs_flat,
    input  logic                    host_irq_clr,
    output logic                    irq
);

    host_state_t       r_state;
    host_state_t       w_next_state;
    logic              r_hold_we;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [REG_W-1:0]  r_hold_wdata;
    logic              r_host_ack;
    logic [REG_W-1:0]  r_host_rdata;
    logic              w_latch;
    logic              w_issue_go;
    logic              w_host_wr;
    logic [REG_W-1:0]  w_host_rd_data;

    // Any I2C strobe stalls ISSUE, which keeps host reads coherent with I2C writes.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_issue_go   = 1'b0;
        w_host_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (host_req) begin
                    w_latch      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i2c_wr_en) begin
                    w_issue_go   = 1'b1;
                    w_host_wr    = r_hold_we;
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_hold_we    <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else if (w_latch) begin
            r_hold_we    <= host_we;
            r_hold_addr  <= host_addr;
            r_hold_wdata <= host_wdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_host_ack <= w_issue_go;
            if (w_issue_go && !r_hold_we) begin
                r_host_rdata <= w_host_rd_data;
            end
        end
    end

    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

    i2c_reg_bank #(
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .i_i2c_wr_en  (i2c_wr_en),
        .i_i2c_addr   (i2c_addr),
        .i_i2c_wdata  (i2c_wr_data),
        .i_host_wr_en (w_host_wr),
        .i_host_addr  (r_hold_addr),
        .i_host_wdata (r_hold_wdata),
        .i_rd0_addr   (i2c_addr),
        .o_rd0_data   (i2c_rd_data),
        .i_rd1_addr   (r_hold_addr),
        .o_rd1_data   (w_host_rd_data),
        .o_regs_flat  (regs_flat)
    );

`ifdef I2C_REG_IRQ_EN
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_flags;
    logic [DEPTH-1:0] w_flags_next;
    logic             r_irq;

    // Set is applied after clear so a same-cycle I2C write keeps its flag.
    always_comb begin
        w_flags_next = r_flags;
        if (host_irq_clr) begin
            w_flags_next = '0;
        end
        if (i2c_wr_en && addr_in_range(i2c_addr, DEPTH)) begin
            w_flags_next[i2c_addr[IDX_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_flags <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= w_flags_next;
            r_irq   <= |w_flags_next;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = host_irq_clr;
    assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Randomized scoreboard bench for i2c_reg_arbiter; the expected host responses come from
// an array-based register model and are checked by an independent ack monitor.
module tb_i2c_reg_arbiter;

    localparam int         DEPTH     = 32;
    localparam logic [7:0] RESET_VAL = 8'h5A;

    logic             hclk;
    logic             hresetn;
    logic             i2c_wr_en;
    logic [7:0]       i2c_addr;
    logic [7:0]       i2c_wr_data;
    logic [7:0]       i2c_rd_data;
    logic             host_req;
    logic             host_we;
    logic [7:0]       host_addr;
    logic [7:0]       host_wdata;
    logic             host_ack;
    logic [7:0]       host_rdata;
    logic [DEPTH*8-1:0] regs_flat;
    logic             host_irq_clr;
    logic             irq;

    typedef struct {
        bit       we;
        bit [7:0] addr;
        bit [7:0] rdata;
        int       lat;
        int       issue;
    } exp_t;

    exp_t     sbq[$];
    bit [7:0] model [256];
`ifdef I2C_REG_IRQ_EN
    bit [DEPTH-1:0] mflags;
`endif
    bit [7:0] lastRd;
    int       checks;
    int       errors;
    int       cyc;
    bit       prevAck;

    i2c_reg_arbiter #(
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .i2c_wr_en    (i2c_wr_en),
        .i2c_addr     (i2c_addr),
        .i2c_wr_data  (i2c_wr_data),
        .i2c_rd_data  (i2c_rd_data),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .regs_flat    (regs_flat),
        .host_irq_clr (host_irq_clr),
        .irq          (irq)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit [7:0] modelRead(input bit [7:0] a);
        return (int'(a) < DEPTH) ? model[a] : 8'h00;
    endfunction

    function automatic logic [255:0] modelFlat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    function automatic bit modelIrq();
`ifdef I2C_REG_IRQ_EN
        return |mflags;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelI2cWrite(input bit [7:0] a, input bit [7:0] d, input bit clr);
`ifdef I2C_REG_IRQ_EN
        if (clr) mflags = '0;
        if (int'(a) < DEPTH) mflags[int'(a)] = 1'b1;
`endif
        if (int'(a) < DEPTH) model[a] = d;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 256; i++) model[i] = (i < DEPTH) ? RESET_VAL : 8'h00;
`ifdef I2C_REG_IRQ_EN
        mflags = '0;
`endif
        lastRd = 8'h00;
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Ack monitor: every host_ack consumes one scoreboard entry.
    always @(negedge hclk) begin
        if (hresetn && host_ack) begin
            if (prevAck) begin
                checks++;
                errors++;
                $display("[TB] FAIL ack_pulse actual=2+cycles required=1cycle");
            end else if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ack_unexpected actual=ack required=no_ack");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("ack_latency", 256'(cyc - e.issue), 256'(e.lat));
                checkOutput(e.we ? "host_rdata_held" : "host_rdata", 256'(host_rdata), 256'(e.rdata));
            end
        end
        prevAck = host_ack;
    end

    task automatic applyStimulus(input bit we, input bit [7:0] addr, input bit [7:0] wdata,
                                 input int nstall, input bit [7:0] saddr, input bit [7:0] sdata);
        exp_t e;
        bit   seen;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        for (int j = 0; j < nstall; j++) modelI2cWrite(saddr, sdata ^ 8'(j), 1'b0);
        e.we    = we;
        e.addr  = addr;
        e.lat   = 2 + nstall;
        e.issue = cyc;
        if (we) begin
            if (int'(addr) < DEPTH) model[addr] = wdata;
        end else begin
            lastRd = modelRead(addr);
        end
        e.rdata = lastRd;
        sbq.push_back(e);
        tick();
        for (int j = 0; j < nstall; j++) begin
            i2c_wr_en   = 1'b1;
            i2c_addr    = saddr;
            i2c_wr_data = sdata ^ 8'(j);
            tick();
        end
        i2c_wr_en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge hclk);
            if (host_ack) seen = 1'b1;
            else tick();
        end
        checkOutput("ack_seen", 256'(seen), 256'(1));
        tick();
        host_req = 1'b0;
        checkOutput("regs_flat", regs_flat, modelFlat());
        checkOutput("irq", 256'(irq), 256'(modelIrq()));
    endtask

    task automatic i2cWrite(input bit [7:0] a, input bit [7:0] d, input bit clr);
        i2c_wr_en    = 1'b1;
        i2c_addr     = a;
        i2c_wr_data  = d;
        host_irq_clr = clr;
        modelI2cWrite(a, d, clr);
        tick();
        i2c_wr_en    = 1'b0;
        host_irq_clr = 1'b0;
        @(negedge hclk);
        checkOutput("i2c_rd_data", 256'(i2c_rd_data), 256'(modelRead(a)));
        checkOutput("regs_flat_i2c", regs_flat, modelFlat());
        checkOutput("irq_i2c", 256'(irq), 256'(modelIrq()));
        tick();
    endtask

    task automatic irqClear();
        host_irq_clr = 1'b1;
`ifdef I2C_REG_IRQ_EN
        mflags = '0;
`endif
        tick();
        host_irq_clr = 1'b0;
        @(negedge hclk);
        checkOutput("irq_clear", 256'(irq), 256'(modelIrq()));
        tick();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        prevAck      = 1'b0;
        hresetn      = 1'b0;
        i2c_wr_en    = 1'b0;
        i2c_addr     = 8'h00;
        i2c_wr_data  = 8'h00;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = 8'h00;
        host_wdata   = 8'h00;
        host_irq_clr = 1'b0;
        modelReset();

        repeat (2) @(negedge hclk);
        checkOutput("reset_regs", regs_flat, modelFlat());
        checkOutput("reset_ack", 256'(host_ack), 256'(0));
        checkOutput("reset_irq", 256'(irq), 256'(0));
        checkOutput("reset_rdata", 256'(host_rdata), 256'(0));
        #2 hresetn = 1'b1;
        tick();

        applyStimulus(1'b1, 8'h05, 8'hA5, 0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h05, 8'h00, 0, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h03, 8'hC3, 1, 8'h03, 8'h3C);
        applyStimulus(1'b0, 8'h03, 8'h00, 0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h07, 8'h00, 1, 8'h07, 8'h77);
        applyStimulus(1'b1, 8'h40, 8'hEE, 0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h40, 8'h00, 0, 8'h00, 8'h00);
        i2c_addr = 8'h40;
        @(negedge hclk);
        checkOutput("i2c_rd_unimpl", 256'(i2c_rd_data), 256'(modelRead(8'h40)));
        tick();
        i2cWrite(8'h40, 8'h99, 1'b0);

        irqClear();
        i2cWrite(8'h02, 8'h22, 1'b0);
        i2cWrite(8'h04, 8'h44, 1'b1);
        irqClear();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                i2cWrite(8'($urandom_range(0, 47)), 8'($urandom), $urandom_range(0, 3) == 0);
            end else begin
                bit [7:0] a;
                a = 8'($urandom_range(0, 39));
                applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 2),
                              ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 39)), 8'($urandom));
            end
        end

        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h09;
        host_wdata = 8'hE1;
        tick();
        hresetn  = 1'b0;
        host_req = 1'b0;
        modelReset();
        @(negedge hclk);
        checkOutput("midreset_regs", regs_flat, modelFlat());
        checkOutput("midreset_ack", 256'(host_ack), 256'(0));
        checkOutput("midreset_rdata", 256'(host_rdata), 256'(0));
        checkOutput("midreset_irq", 256'(irq), 256'(0));
        tick();
        hresetn = 1'b1;
        repeat (3) tick();
        checkOutput("postreset_regs", regs_flat, modelFlat());
        applyStimulus(1'b1, 8'h09, 8'h19, 0, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h09, 8'h00, 0, 8'h00, 8'h00);

        repeat (4) tick();
        checkOutput("scoreboard_empty", 256'(sbq.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
